// File: rtl/fram_bist_pkg.sv
// Shared types, LED bit positions and the test-pattern generator for the FRAM BIST sequencer.
package fram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_CMP     = 3'd5,
    ST_DONE    = 3'd6
  } bist_state_e;

  typedef enum logic [1:0] {
    PAT_CONST    = 2'd0,
    PAT_ADDR_XOR = 2'd1,
    PAT_WALK1    = 2'd2,
    PAT_ALT      = 2'd3
  } pat_mode_e;

  localparam int LED_BUSY    = 0;
  localparam int LED_WRITE   = 1;
  localparam int LED_READ    = 2;
  localparam int LED_DONE    = 3;
  localparam int LED_PASS    = 4;
  localparam int LED_ERR     = 5;
  localparam int LED_TIMEOUT = 6;
  localparam int LED_ABORTED = 7;

  // Works on 32-bit containers so one function serves every width; the caller
  // truncates the result to its data width (widths above 32 are not supported).
  function automatic logic [31:0] bist_pattern(input pat_mode_e   mode,
                                               input logic [31:0] seed,
                                               input logic [31:0] index,
                                               input logic [31:0] addr,
                                               input int          data_width);
    logic [31:0] pat;
    case (mode)
      PAT_CONST:    pat = seed;
      PAT_ADDR_XOR: pat = addr ^ seed;
      PAT_WALK1:    pat = 32'd1 << (index % 32'(data_width));
      default:      pat = index[0] ? ~seed : seed;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/fram_bist_sequencer_if.sv
// Valid/ready memory-request and response bus between the BIST sequencer and the FRAM command master.
interface fram_bist_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/fram_bist_timeout.sv
// Response-timeout counter: cleared at request acceptance, counts waiting cycles, flags the limit.
module fram_bist_timeout #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The edge that sees cnt == LIMIT-1 without a response is LIMIT cycles after acceptance.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/fram_bist_sequencer.sv
// FRAM built-in self-test: writes a pattern over an address window, reads it back and reports errors.
module fram_bist_sequencer
  import fram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int BASE_ADDR      = 4,
  parameter int NUM_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [DATA_WIDTH-1:0]    seed,
  input  logic                     stop_on_error,
  fram_bist_sequencer_if.master    mem,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_exp,
  output logic [DATA_WIDTH-1:0]    first_err_got,
  output logic [7:0]               leds
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_WR_REQ  = ST_WR_REQ;
  localparam logic [2:0] S_WR_WAIT = ST_WR_WAIT;
  localparam logic [2:0] S_RD_REQ  = ST_RD_REQ;
  localparam logic [2:0] S_RD_WAIT = ST_RD_WAIT;
  localparam logic [2:0] S_CMP     = ST_CMP;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]            state;
  logic [IDX_W-1:0]      idx;
  pat_mode_e             mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  stop_q;
  logic                  aborted_q;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_pat;
  logic                  in_req;
  logic                  in_wait;
  logic                  accept;
  logic                  rsp;
  logic                  abort_any;
  logic                  mismatch;
  logic                  tmo_expired;

  // Window address wraps modulo 2^ADDR_WIDTH by truncation.
  assign cur_addr  = ADDR_WIDTH'(32'(BASE_ADDR) + 32'(idx));
  assign cur_pat   = DATA_WIDTH'(bist_pattern(mode_q, 32'(seed_q), 32'(idx),
                                              32'(cur_addr), DATA_WIDTH));

  assign in_req    = (state == S_WR_REQ) || (state == S_RD_REQ);
  assign in_wait   = (state == S_WR_WAIT) || (state == S_RD_WAIT);
  assign accept    = in_req && mem.mem_req_ready;
  assign rsp       = in_wait && mem.mem_rsp_valid;
  assign abort_any = aborted_q || abort;
  assign mismatch  = (rd_q != cur_pat);

  // Request outputs decode straight from the state register, so an asynchronous
  // reset drops mem_req_valid without waiting for a clock edge.
  assign mem.mem_req_valid = in_req;
  assign mem.mem_req_we    = (state == S_WR_REQ);
  assign mem.mem_req_addr  = in_req ? cur_addr : '0;
  assign mem.mem_req_wdata = (state == S_WR_REQ) ? cur_pat : '0;

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0) && !timeout && !aborted_q;

  fram_bist_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (in_wait && !mem.mem_rsp_valid),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      mode_q         <= PAT_CONST;
      seed_q         <= '0;
      rd_q           <= '0;
      stop_q         <= 1'b0;
      aborted_q      <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      if (busy && abort) aborted_q <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_WR_REQ;
            idx            <= '0;
            mode_q         <= pat_mode_e'(mode);
            seed_q         <= seed;
            stop_q         <= stop_on_error;
            aborted_q      <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
          end
        end
        S_WR_REQ: if (accept) state <= S_WR_WAIT;
        S_RD_REQ: if (accept) state <= S_RD_WAIT;
        S_WR_WAIT: begin
          if (rsp) begin
            if (abort_any) begin
              state <= S_DONE;
            end else if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= S_RD_REQ;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_WR_REQ;
            end
          end else if (tmo_expired) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_RD_WAIT: begin
          if (rsp) begin
            rd_q  <= mem.mem_rsp_rdata;
            // A read completing after an abort is drained but never compared.
            state <= abort_any ? S_DONE : S_CMP;
          end else if (tmo_expired) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_CMP: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              first_err_addr <= cur_addr;
              first_err_exp  <= cur_pat;
              first_err_got  <= rd_q;
            end
          end
          if ((mismatch && stop_q) || abort_any || (idx == LAST_IDX)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_RD_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every bit gets a default before the individual assignments, so no latch is inferred.
  always_comb begin
    leds              = '0;
    leds[LED_BUSY]    = busy;
    leds[LED_WRITE]   = (state == S_WR_REQ) || (state == S_WR_WAIT);
    leds[LED_READ]    = (state == S_RD_REQ) || (state == S_RD_WAIT) || (state == S_CMP);
    leds[LED_DONE]    = done;
    leds[LED_PASS]    = pass;
    leds[LED_ERR]     = (err_count != '0);
    leds[LED_TIMEOUT] = timeout;
    leds[LED_ABORTED] = aborted_q;
  end

endmodule
